// File: rtl/instruction_fetch_stage.sv
// Sequential instruction fetch: issues word requests, buffers in-order responses
// with their addresses, and streams one instruction per cycle. Optional FETCH_BYPASS_EN.
module instruction_fetch_stage #(
  parameter int                       instructionWidth = 32,
  parameter int                       addressSize      = 64,
  parameter logic [addressSize-1:0]   resetVector      = '0,
  parameter int                       fifoDepth        = 4
) (
  input  logic                        clock_i,
  input  logic                        resetn_i,
  input  logic                        stall_i,
  input  logic                        redirect_i,
  input  logic [addressSize-1:0]      redirectAddress_i,
  output logic                        memReq_o,
  output logic [addressSize-1:0]      memAddress_o,
  input  logic                        memReady_i,
  input  logic                        memValid_i,
  input  logic [instructionWidth-1:0] memData_i,
  output logic [instructionWidth-1:0] instruction_o,
  output logic [addressSize-1:0]      address_o,
  output logic                        enable_o
);

  localparam int PW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic [addressSize-1:0]      fetch_pc;
  logic [addressSize-1:0]      resp_pc;
  logic [CW-1:0]               outstanding;
  logic [CW-1:0]               discard;
  logic [CW-1:0]               fifo_count;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [instructionWidth-1:0] word_mem [fifoDepth];
  logic [addressSize-1:0]      addr_mem [fifoDepth];

  logic [SW-1:0]               credit_used;
  logic [addressSize-1:0]      redirect_target;
  logic                        fire;
  logic                        fifo_empty;
  logic                        drop_resp;
  logic                        accept;
  logic                        bypass;
  logic                        push;
  logic                        pop;

  // Requests are only issued while every in-flight word is guaranteed a FIFO slot.
  assign credit_used     = SW'(outstanding) + SW'(fifo_count);
  assign memReq_o        = resetn_i && !redirect_i && (credit_used < SW'(fifoDepth));
  assign memAddress_o    = fetch_pc;
  assign fire            = memReq_o && memReady_i;
  assign redirect_target = {redirectAddress_i[addressSize-1:2], 2'b00};

  assign fifo_empty = (fifo_count == '0);
  assign drop_resp  = memValid_i && (discard != '0);
  assign accept     = memValid_i && (discard == '0) && !redirect_i;
`ifdef FETCH_BYPASS_EN
  assign bypass     = accept && fifo_empty && !stall_i;
`else
  assign bypass     = 1'b0;
`endif
  assign push       = accept && !bypass;
  assign pop        = !fifo_empty && !stall_i && !redirect_i;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      fetch_pc      <= resetVector;
      resp_pc       <= resetVector;
      outstanding   <= '0;
      discard       <= '0;
      fifo_count    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      enable_o      <= 1'b0;
      instruction_o <= '0;
      address_o     <= '0;
      for (int i = 0; i < fifoDepth; i++) begin
        word_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(memValid_i);
      enable_o    <= pop || bypass;

      if (redirect_i) begin
        // Every response still in flight belongs to the old stream, including
        // ones already marked for dropping, so the drop count becomes exactly
        // the in-flight count after this cycle's response.
        fetch_pc   <= redirect_target;
        resp_pc    <= redirect_target;
        discard    <= outstanding - CW'(memValid_i);
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (fire) begin
          fetch_pc <= fetch_pc + addressSize'(4);
        end
        if (drop_resp) begin
          discard <= discard - CW'(1);
        end
        if (accept) begin
          resp_pc <= resp_pc + addressSize'(4);
        end
        if (push) begin
          word_mem[wr_ptr] <= memData_i;
          addr_mem[wr_ptr] <= resp_pc;
          wr_ptr           <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end

      if (pop) begin
        instruction_o <= word_mem[rd_ptr];
        address_o     <= addr_mem[rd_ptr];
      end else if (bypass) begin
        instruction_o <= memData_i;
        address_o     <= resp_pc;
      end
    end
  end

endmodule
